score_keeper: RTL and testbench

//  Tetris score/level accumulator; the stage directly upstream of the 7-segment display driver.

---
 rtl/tetris_pkg.sv | 25 ++
 rtl/sat_add14.sv | 16 +
 rtl/score_keeper.sv | 99 +++++++++
 tb/tb_score_keeper.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared constants, base-point table and FSM encoding for the Tetris score path.
package tetris_pkg;

  localparam logic [13:0] SCORE_MAX       = 14'd9999;
  localparam logic [3:0]  MAX_LEVEL       = 4'd9;
  localparam logic [3:0]  LINES_PER_LEVEL = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_UPD  = 2'd2
  } state_t;

  // Base points for a single clear; illegal counts map to 0.
  function automatic logic [3:0] pts(input logic [2:0] n);
    case (n)
      3'd1:    pts = 4'd1;
      3'd2:    pts = 4'd3;
      3'd3:    pts = 4'd5;
      3'd4:    pts = 4'd8;
      default: pts = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/sat_add14.sv
// Combinational 14-bit adder that clamps its result at SCORE_MAX.
module sat_add14
  import tetris_pkg::*;
(
  input  logic [13:0] i_a,
  input  logic [13:0] i_b,
  output logic [13:0] o_sum
);

  logic [14:0] w_sum;

  // One extra bit keeps the carry so the clamp sees the true sum instead of a wrapped value.
  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum = (w_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : w_sum[13:0];

endmodule

// File: rtl/score_keeper.sv
// Tetris score/lines/level accumulator: points x (level+1) by repeated addition, saturating at 9999.
module score_keeper
  import tetris_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        game_new,
  input  logic        game_over,
  input  logic        clear_valid,
  input  logic [2:0]  clear_lines,
  output logic        clear_ready,
  output logic [13:0] score,
  output logic [13:0] lines_total,
  output logic [3:0]  level,
  output logic        busy
);

  state_t      r_state;
  logic [13:0] r_score;
  logic [13:0] r_lines;
  logic [3:0]  r_level;
  logic [3:0]  r_rep;
  logic [3:0]  r_lvl_lines;
  logic [3:0]  r_base;
  logic [2:0]  r_n;

  logic        w_accept;
  logic        w_legal;
  logic [13:0] w_score_next;
  logic [13:0] w_lines_next;
  logic [4:0]  w_lvl_sum;
  logic [4:0]  w_lvl_wrap;

  assign clear_ready = (r_state == ST_IDLE) & ~game_over;
  assign busy        = (r_state != ST_IDLE);
  assign score       = r_score;
  assign lines_total = r_lines;
  assign level       = r_level;

  assign w_accept   = clear_valid & clear_ready;
  assign w_legal    = (clear_lines != 3'd0) && (clear_lines <= 3'd4);
  assign w_lvl_sum  = {1'b0, r_lvl_lines} + {2'b00, r_n};
  assign w_lvl_wrap = w_lvl_sum - {1'b0, LINES_PER_LEVEL};

  sat_add14 u_score_add (
    .i_a   (r_score),
    .i_b   ({10'd0, r_base}),
    .o_sum (w_score_next)
  );

  sat_add14 u_lines_add (
    .i_a   (r_lines),
    .i_b   ({11'd0, r_n}),
    .o_sum (w_lines_next)
  );

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || game_new) begin
      r_state     <= ST_IDLE;
      r_score     <= '0;
      r_lines     <= '0;
      r_level     <= '0;
      r_rep       <= '0;
      r_lvl_lines <= '0;
      r_base      <= '0;
      r_n         <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_legal) begin
            r_base  <= pts(clear_lines);
            r_n     <= clear_lines;
            r_rep   <= r_level;
            r_state <= ST_ADD;
          end
        end
        ST_ADD: begin
          r_score <= w_score_next;
          if (r_rep == 4'd0) r_state <= ST_UPD;
          else               r_rep   <= r_rep - 4'd1;
        end
        ST_UPD: begin
          r_lines <= w_lines_next;
          // A single event adds at most 4 lines, so one wrap is enough.
          if (w_lvl_sum >= {1'b0, LINES_PER_LEVEL}) begin
            r_lvl_lines <= w_lvl_wrap[3:0];
            if (r_level != MAX_LEVEL) r_level <= r_level + 4'd1;
          end else begin
            r_lvl_lines <= w_lvl_sum[3:0];
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: hand-computed vectors plus a small reference model for long ramps.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        reset;
  logic        game_new;
  logic        game_over;
  logic        clear_valid;
  logic [2:0]  clear_lines;
  logic        clear_ready;
  logic [13:0] score;
  logic [13:0] lines_total;
  logic [3:0]  level;
  logic        busy;

  int n_total = 0;
  int n_bad   = 0;
  int m_score, m_lines, m_level;
  int cyc;

  score_keeper dut (
    .clk         (clk),
    .reset       (reset),
    .game_new    (game_new),
    .game_over   (game_over),
    .clear_valid (clear_valid),
    .clear_lines (clear_lines),
    .clear_ready (clear_ready),
    .score       (score),
    .lines_total (lines_total),
    .level       (level),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_pts(input int n);
    case (n)
      1: return 1;
      2: return 3;
      3: return 5;
      4: return 8;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_score = 0; m_lines = 0; m_level = 0;
  endtask

  task automatic model_event(input int n);
    m_score = m_score + ref_pts(n) * (m_level + 1);
    if (m_score > 9999) m_score = 9999;
    m_lines = m_lines + ((n >= 1 && n <= 4) ? n : 0);
    if (m_lines > 9999) m_lines = 9999;
    m_level = (m_lines / 10 > 9) ? 9 : m_lines / 10;
  endtask

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic send(input logic [2:0] n, output int busy_cycles);
    int guard = 0;
    while (!clear_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 0, 1);
    clear_valid = 1'b1;
    clear_lines = n;
    @(negedge clk);
    clear_valid = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 50) begin
      busy_cycles++;
      @(negedge clk);
    end
    if (busy_cycles >= 50) check("busy_timeout", 0, 1);
  endtask

  task automatic check_outputs(input string tag, input int s, input int l, input int lv);
    check({tag, "_score"}, int'(score), s);
    check({tag, "_lines"}, int'(lines_total), l);
    check({tag, "_level"}, int'(level), lv);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b0; game_new = 1'b0; game_over = 1'b0;
    clear_valid = 1'b0; clear_lines = 3'd0;
    @(negedge clk);

    // Reset state
    do_reset();
    check_outputs("rst", 0, 0, 0);
    check("rst_ready", int'(clear_ready), 1);
    check("rst_busy", int'(busy), 0);

    // Single tetris at level 0: ADD + UPD
    send(3'd4, cyc);
    check("t2_busy_cycles", cyc, 2);
    check_outputs("t2", 8, 4, 0);
    check("t2_ready", int'(clear_ready), 1);

    // Level-up on third event; new level applies to fourth
    send(3'd4, cyc);
    send(3'd4, cyc);
    check_outputs("t3a", 24, 12, 1);
    send(3'd2, cyc);
    check("t3_busy_cycles", cyc, 3);
    check_outputs("t3b", 30, 14, 1);

    // Illegal counts accepted as no-ops
    send(3'd0, cyc);
    check("t5_zero_busy", cyc, 0);
    check_outputs("t5_zero", 30, 14, 1);
    check("t5_zero_ready", int'(clear_ready), 1);
    send(3'd6, cyc);
    check("t5_six_busy", cyc, 0);
    check_outputs("t5_six", 30, 14, 1);

    // game_over mid-event: in-flight event completes, new events blocked
    clear_valid = 1'b1; clear_lines = 3'd1;
    @(negedge clk);
    clear_valid = 1'b0;
    game_over = 1'b1;
    check("go_busy_inflight", int'(busy), 1);
    repeat (4) @(negedge clk);
    check_outputs("go_done", 32, 15, 1);
    check("go_ready", int'(clear_ready), 0);
    clear_valid = 1'b1; clear_lines = 3'd4;
    repeat (3) @(negedge clk);
    clear_valid = 1'b0;
    check("go_frozen_busy", int'(busy), 0);
    check_outputs("go_frozen", 32, 15, 1);
    game_over = 1'b0;
    @(negedge clk);
    check("go_release_ready", int'(clear_ready), 1);

    // game_new and clear_valid together: restart wins
    game_new = 1'b1; clear_valid = 1'b1; clear_lines = 3'd4;
    @(negedge clk);
    game_new = 1'b0; clear_valid = 1'b0;
    model_reset();
    check("gn_drop_busy", int'(busy), 0);
    check_outputs("gn_drop", 0, 0, 0);

    // Ramp to level 5, then restart during ADD
    while (m_level < 5) begin
      send(3'd4, cyc);
      model_event(4);
      check("ramp5_score", int'(score), m_score);
    end
    check_outputs("lvl5", m_score, m_lines, 5);
    clear_valid = 1'b1; clear_lines = 3'd1;
    @(negedge clk);
    clear_valid = 1'b0;
    check("gn_in_add_busy", int'(busy), 1);
    @(negedge clk);
    game_new = 1'b1;
    @(negedge clk);
    game_new = 1'b0;
    model_reset();
    check_outputs("gn_abort", 0, 0, 0);
    check("gn_abort_busy", int'(busy), 0);
    check("gn_abort_ready", int'(clear_ready), 1);

    // Ramp to level 9 and near the ceiling, then saturate
    do_reset();
    while (m_score + 80 <= 9999) begin
      send(3'd4, cyc);
      model_event(4);
      if (score != 14'(m_score)) check("ramp9_score", int'(score), m_score);
    end
    check_outputs("pre_sat", m_score, m_lines, 9);
    send(3'd4, cyc);
    check("sat_busy_cycles", cyc, 11);
    check("sat_score", int'(score), 9999);
    check("sat_level", int'(level), 9);
    send(3'd1, cyc);
    check("sat_hold_score", int'(score), 9999);
    check("sat_hold_level", int'(level), 9);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
